// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Build option: define JAL_EN to include the jal instruction and its JAL state.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
`ifdef JAL_EN
        , S_JAL    = 4'd12
`endif
    } state_t;

`ifdef JAL_EN
    localparam logic JAL_BUILT = 1'b1;
`else
    localparam logic JAL_BUILT = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic is_mem;
        logic is_load;
        logic is_rtype;
        logic is_imm;
        logic is_branch;
        logic is_bne;
        logic is_j;
        logic is_jal;
        logic is_illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_classifier.sv
// Combinational opcode classifier feeding the control FSM dispatch.
// jal is always recognised here; whether it is legal depends on JAL_EN in the FSM.
module opcode_classifier
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_class
);

    // Map each opcode onto its instruction class
    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_LW:    begin o_class.is_mem = 1'b1; o_class.is_load = 1'b1; end
            OP_SW:    o_class.is_mem    = 1'b1;
            OP_RTYPE: o_class.is_rtype  = 1'b1;
            OP_ADDI,
            OP_ANDI,
            OP_ORI:   o_class.is_imm    = 1'b1;
            OP_BEQ:   o_class.is_branch = 1'b1;
            OP_BNE:   begin o_class.is_branch = 1'b1; o_class.is_bne = 1'b1; end
            OP_J:     o_class.is_j      = 1'b1;
            OP_JAL:   o_class.is_jal    = 1'b1;
            default:  o_class.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM driving the shared datapath controls.
// Build option: JAL_EN adds the JAL state; without it opcode 000011 is illegal.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    op_class_t  w_class;
    logic       w_reject;

    logic       w_pc_write, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source;
    logic       w_reg_write, w_alu_src_a, w_imm_zext, w_instr_done;
    logic [2:0] w_alu_op;

    opcode_classifier u_classifier (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    assign w_reject = w_class.is_illegal | (w_class.is_jal & ~JAL_BUILT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky undecodable-opcode flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_DECODE && w_reject) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = RDST_RT;
        w_mem_to_reg = M2R_ALUOUT;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_B;
        w_imm_zext   = 1'b0;
        w_alu_op     = ALU_ADD;
        w_pc_source  = PCSRC_ALU;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU adds the shifted immediate to PC+4 here for a possible branch
                w_alu_src_b = SRCB_IMM_SH;
                if (w_reject) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else if (w_class.is_mem) begin
                    w_next = S_MEM_ADDR;
                end else if (w_class.is_rtype) begin
                    w_next = S_R_EXEC;
                end else if (w_class.is_imm) begin
                    w_next = S_I_EXEC;
                end else if (w_class.is_branch) begin
                    w_next = S_BRANCH;
                end else if (w_class.is_j) begin
                    w_next = S_JUMP;
                end else begin
`ifdef JAL_EN
                    w_next = S_JAL;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                if (w_class.is_load) begin
                    w_next = S_MEM_RD;
                end else begin
                    w_next = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                w_i_or_d   = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_MDR;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_i_or_d    = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    w_next = S_MEM_WR;
                end
            end
            S_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_FUNCT;
                w_next      = S_R_WB;
            end
            S_R_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = RDST_RD;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                if (opcode == OP_ANDI) begin
                    w_alu_op   = ALU_AND;
                    w_imm_zext = 1'b1;
                end else if (opcode == OP_ORI) begin
                    w_alu_op   = ALU_OR;
                    w_imm_zext = 1'b1;
                end else begin
                    w_alu_op = ALU_ADD;
                end
                w_next = S_I_WB;
            end
            S_I_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALU_SUB;
                w_pc_source  = PCSRC_ALUOUT;
                w_pc_write   = w_class.is_bne ? ~alu_zero : alu_zero;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCSRC_JUMP;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef JAL_EN
            S_JAL: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCSRC_JUMP;
                w_reg_write  = 1'b1;
                w_reg_dst    = RDST_RA;
                w_mem_to_reg = M2R_PC;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks the outputs immediately so an abort drops strobes in the same cycle
    assign pc_write   = w_pc_write   & ~reset;
    assign i_or_d     = w_i_or_d     & ~reset;
    assign mem_read   = w_mem_read   & ~reset;
    assign mem_write  = w_mem_write  & ~reset;
    assign ir_write   = w_ir_write   & ~reset;
    assign reg_dst    = reset ? 2'b00 : w_reg_dst;
    assign mem_to_reg = reset ? 2'b00 : w_mem_to_reg;
    assign reg_write  = w_reg_write  & ~reset;
    assign alu_src_a  = w_alu_src_a  & ~reset;
    assign alu_src_b  = reset ? 2'b00 : w_alu_src_b;
    assign imm_zext   = w_imm_zext   & ~reset;
    assign alu_op     = reset ? 3'b000 : w_alu_op;
    assign pc_source  = reset ? 2'b00 : w_pc_source;
    assign instr_done = w_instr_done & ~reset;
    assign illegal_op = r_illegal    & ~reset;
    assign state      = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; expected output vectors are hand-written per cycle.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset, alu_zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_a, imm_zext, instr_done, illegal_op;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [24:0] obs;
    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, imm_zext, alu_op, pc_source, instr_done, illegal_op, state};

    function automatic logic [24:0] ev(input logic [3:0] st, input logic pcw, iord, mr, mw, irw,
                                       input logic [1:0] rd, m2r, input logic rw, asa,
                                       input logic [1:0] asb, input logic zx, input logic [2:0] aop,
                                       input logic [1:0] pcs, input logic done, ill);
        return {pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, zx, aop, pcs, done, ill, st};
    endfunction

    function automatic logic [24:0] f_fetch(input logic rdy, input logic ill);
        return ev(4'd0, rdy, 1'b0, 1'b1, 1'b0, rdy, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 3'b000, 2'b00, 1'b0, ill);
    endfunction

    function automatic logic [24:0] f_decode(input logic done, input logic ill);
        return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000, 2'b00, done, ill);
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy, input logic z);
        @(posedge clk);
        #1;
        reset = rst; opcode = op; mem_ready = rdy; alu_zero = z;
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b0; alu_zero = 1'b0;
        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 6'b000000, 1'b1, 1'b0);
            chk("reset_zero", 25'd0);
        end

        // R-type, 4 cycles
        cyc(1'b0, 6'b000000, 1'b1, 1'b0); chk("r_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b000000, 1'b1, 1'b0); chk("r_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b000000, 1'b1, 1'b0);
        chk("r_exec", ev(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b010, 2'b00, 0, 0));
        cyc(1'b0, 6'b000000, 1'b1, 1'b0);
        chk("r_wb", ev(4'd7, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 0, 3'b000, 2'b00, 1, 0));

        // lw with two wait cycles in MEM_RD, 7 cycles
        cyc(1'b0, 6'b100011, 1'b1, 1'b0); chk("lw_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b100011, 1'b1, 1'b0); chk("lw_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b100011, 1'b1, 1'b0);
        chk("lw_addr", ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b100011, 1'b0, 1'b0);
        chk("lw_rd_wait1", ev(4'd3, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b100011, 1'b0, 1'b0);
        chk("lw_rd_wait2", ev(4'd3, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b100011, 1'b1, 1'b0);
        chk("lw_rd_ready", ev(4'd3, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b100011, 1'b0, 1'b0);
        chk("lw_wb", ev(4'd4, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0, 3'b000, 2'b00, 1, 0));

        // ori: zero-extended OR
        cyc(1'b0, 6'b001101, 1'b1, 1'b0); chk("ori_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b001101, 1'b0, 1'b0); chk("ori_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b001101, 1'b0, 1'b0);
        chk("ori_exec", ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 1, 3'b100, 2'b00, 0, 0));
        cyc(1'b0, 6'b001101, 1'b0, 1'b0);
        chk("ori_wb", ev(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 3'b000, 2'b00, 1, 0));

        // addi: sign-extended add
        cyc(1'b0, 6'b001000, 1'b1, 1'b0); chk("addi_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b001000, 1'b0, 1'b0); chk("addi_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b001000, 1'b0, 1'b0);
        chk("addi_exec", ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b001000, 1'b0, 1'b0);
        chk("addi_wb", ev(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 3'b000, 2'b00, 1, 0));

        // beq taken
        cyc(1'b0, 6'b000100, 1'b1, 1'b1); chk("beq_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b000100, 1'b1, 1'b1); chk("beq_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b000100, 1'b1, 1'b1);
        chk("beq_taken", ev(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b001, 2'b01, 1, 0));

        // bne with one fetch wait: not taken when zero, taken when not zero
        cyc(1'b0, 6'b000101, 1'b0, 1'b1); chk("bne_fetch_wait", f_fetch(1'b0, 1'b0));
        cyc(1'b0, 6'b000101, 1'b1, 1'b1); chk("bne_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b000101, 1'b1, 1'b1); chk("bne_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b000101, 1'b1, 1'b1);
        chk("bne_zero", ev(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b001, 2'b01, 1, 0));
        cyc(1'b0, 6'b000101, 1'b1, 1'b0); chk("bne2_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b000101, 1'b1, 1'b0); chk("bne2_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b000101, 1'b1, 1'b0);
        chk("bne_nonzero", ev(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b001, 2'b01, 1, 0));

        // j
        cyc(1'b0, 6'b000010, 1'b1, 1'b0); chk("j_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b000010, 1'b1, 1'b0); chk("j_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b000010, 1'b1, 1'b0);
        chk("j_jump", ev(4'd11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b10, 1, 0));

        // sw completing normally
        cyc(1'b0, 6'b101011, 1'b1, 1'b0); chk("sw_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b101011, 1'b1, 1'b0); chk("sw_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b101011, 1'b1, 1'b0);
        chk("sw_addr", ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b101011, 1'b1, 1'b0);
        chk("sw_wr_ready", ev(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 1, 0));

        // sw aborted by reset mid-MEM_WR
        cyc(1'b0, 6'b101011, 1'b1, 1'b0); chk("sw2_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b101011, 1'b0, 1'b0); chk("sw2_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b101011, 1'b0, 1'b0);
        chk("sw2_addr", ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b0, 6'b101011, 1'b0, 1'b0);
        chk("sw2_wr_wait", ev(4'd5, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0, 0));
        cyc(1'b1, 6'b101011, 1'b0, 1'b0); chk("sw2_abort", 25'd0);
        cyc(1'b0, 6'b101011, 1'b1, 1'b0); chk("abort_restart", f_fetch(1'b1, 1'b0));

`ifdef JAL_EN
        cyc(1'b0, 6'b000011, 1'b1, 1'b0); chk("jal_decode", f_decode(1'b0, 1'b0));
        cyc(1'b0, 6'b000011, 1'b1, 1'b0);
        chk("jal_exec", ev(4'd12, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 0, 3'b000, 2'b10, 1, 0));
        cyc(1'b0, 6'b000011, 1'b1, 1'b0); chk("jal_next_fetch", f_fetch(1'b1, 1'b0));
`else
        cyc(1'b0, 6'b000011, 1'b1, 1'b0); chk("jal_illegal_decode", f_decode(1'b1, 1'b0));
        cyc(1'b0, 6'b000011, 1'b1, 1'b0); chk("jal_illegal_fetch", f_fetch(1'b1, 1'b1));
`endif
        cyc(1'b1, 6'b000000, 1'b0, 1'b0); chk("reset2_zero", 25'd0);

        // undecodable opcode: sticky flag until reset
        cyc(1'b0, 6'b111111, 1'b1, 1'b0); chk("ill_fetch", f_fetch(1'b1, 1'b0));
        cyc(1'b0, 6'b111111, 1'b1, 1'b0); chk("ill_decode", f_decode(1'b1, 1'b0));
        cyc(1'b0, 6'b000000, 1'b1, 1'b0); chk("ill_back_fetch", f_fetch(1'b1, 1'b1));
        cyc(1'b0, 6'b000000, 1'b1, 1'b0); chk("ill_sticky_decode", f_decode(1'b0, 1'b1));
        cyc(1'b0, 6'b000000, 1'b1, 1'b0);
        chk("ill_sticky_exec", ev(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b010, 2'b00, 0, 1));
        cyc(1'b1, 6'b000000, 1'b1, 1'b0); chk("ill_reset_zero", 25'd0);
        cyc(1'b0, 6'b000000, 1'b1, 1'b0); chk("ill_cleared", f_fetch(1'b1, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle MIPS control unit: a Moore-style state machine that sequences the shared datapath (single memory, single ALU, register file, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back steps. It sits beside the datapath and takes the IR opcode, the ALU zero flag and a memory-ready handshake. It drives every datapath enable and mux select. Supported instructions: R-type, lw, sw, addi, andi, ori, beq, bne, j and jal.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; valid from DECODE onward
- alu_zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable, with branch condition already resolved
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory strobes, held until mem_ready
- ir_write  out  1  IR load
- reg_dst  out  2  write register: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = immediate, 11 = immediate<<2
- imm_zext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- alu_op  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  sticky flag, set on an undecodable opcode
- state  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL.
- Every output not listed for a state is 0.
- FETCH
  - Drives i_or_d = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 000, pc_source = 00.
  - Holds while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, next state DECODE.
- DECODE
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = 000 (precomputes branch target).
  - Dispatch: lw/sw → MEM_ADDR; 000000 → R_EXEC; addi/andi/ori → I_EXEC; beq/bne → BRANCH; j → JUMP; jal → JAL.
  - Any other opcode: set illegal_op, instr_done = 1, next state FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: i_or_d = 1, mem_read = 1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 00, mem_to_reg = 01, instr_done = 1. Next FETCH.
- MEM_WR: i_or_d = 1, mem_write = 1. Holds until mem_ready; instr_done = 1 on the ready cycle, then FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 010. Next R_WB.
- R_WB: reg_write = 1, reg_dst = 01, mem_to_reg = 00, instr_done = 1. Next FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10.
  - alu_op: 000 for addi, 011 for andi, 100 for ori.
  - imm_zext = 1 for andi/ori only.
  - Next I_WB.
- I_WB: reg_write = 1, reg_dst = 00, mem_to_reg = 00, instr_done = 1. Next FETCH.
- BRANCH
  - Drives alu_src_a = 1, alu_src_b = 00, alu_op = 001, pc_source = 01, instr_done = 1.
  - pc_write = alu_zero for beq, ~alu_zero for bne.
  - Next FETCH.
- JUMP: pc_write = 1, pc_source = 10, instr_done = 1. Next FETCH.
- JAL: pc_write = 1, pc_source = 10, reg_write = 1, reg_dst = 10, mem_to_reg = 10, instr_done = 1. Next FETCH.
- illegal_op clears only on reset.

## Timing
- State is registered; outputs decode combinationally from state and opcode.
- Only pc_write, ir_write and instr_done depend combinationally on inputs (mem_ready, alu_zero).
- While reset = 1, all outputs are 0 and state = FETCH. The first access starts in the cycle after reset deasserts.
- Cycles with zero wait states:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw, R-type, addi/andi/ori | 4 |
| beq, bne, j, jal | 3 |

- Each mem_ready = 0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Strobes stay asserted and stable throughout a wait.
- mem_ready outside a memory state is ignored.
- A reset asserted mid-instruction aborts it and drops all strobes in the same cycle. No partial register write occurs.

## Configuration
- JAL_EN defined: jal (000011) dispatches to JAL as described above.
- JAL_EN undefined:
  - The JAL state is not built.
  - 000011 is treated as illegal: illegal_op is set and the FSM returns to FETCH.
  - reg_dst and mem_to_reg never output 10.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_J, OP_JAL)
  - the alu_op, alu_src_b, reg_dst, mem_to_reg and pc_source encodings
- Sub-module opcode_classifier: combinational opcode → {is_mem, is_load, is_rtype, is_imm, is_branch, is_bne, is_j, is_jal, is_illegal}. It is shared with the FSM dispatch logic.

## Test plan
- Reset held 3 cycles, then released: all outputs 0 during reset; FETCH with mem_read = 1 in the first cycle after release.
- R-type, mem_ready = 1: states FETCH, DECODE, R_EXEC, R_WB. R_WB drives reg_dst = 01, reg_write = 1, instr_done = 1; total 4 cycles.
- lw with mem_ready = 0 for 2 cycles in MEM_RD: mem_read and i_or_d = 1 held; MEM_WB after 7 total cycles; mem_to_reg = 01.
- Branches: beq with alu_zero = 1 gives pc_write = 1 and pc_source = 01 in BRANCH. bne with alu_zero = 1 gives pc_write = 0. Both take 3 cycles.
- Opcode 6'b111111: illegal_op = 1 after DECODE, FSM back in FETCH; illegal_op stays set until reset. With JAL_EN undefined, jal behaves identically.
- jal (JAL_EN defined): reg_dst = 10, mem_to_reg = 10, pc_source = 10, pc_write = 1. Reset asserted mid-MEM_WR: mem_write drops in the same cycle and the FSM restarts at FETCH.
